// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM AHB-Lite line buffer: FSM encodings, bus codes
// and the byte-lane helper used for write-hit merging.
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL_A = 3'd1,
        ST_FILL_D = 3'd2,
        ST_PASS_A = 3'd3,
        ST_PASS_D = 3'd4,
        ST_RESP   = 3'd5
    } psram_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam int CFG_BIT = 23;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Byte lanes touched by a transfer of the given size at the given low address bits.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << a;
            HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/psram_line_store.sv
// Storage for one cached line: one byte-enabled write port, one asynchronous read port.
module psram_line_store #(
    parameter int LINE_WORDS = 4,
    localparam int IW = $clog2(LINE_WORDS)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [LINE_WORDS];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < LINE_WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/psram_ahbl_line_buffer.sv
// Single-line read buffer with write-through between the system AHB-Lite master and
// the PSRAM slave. Data-space read hits complete with zero wait states.
module psram_ahbl_line_buffer
    import psram_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int AW         = 24
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         s_HSEL,
    input  logic [31:0]  s_HADDR,
    input  logic [1:0]   s_HTRANS,
    input  logic [2:0]   s_HSIZE,
    input  logic         s_HWRITE,
    input  logic [31:0]  s_HWDATA,
    input  logic         s_HREADY,
    output logic         s_HREADYOUT,
    output logic [31:0]  s_HRDATA,
    output logic         m_HSEL,
    output logic [31:0]  m_HADDR,
    output logic [1:0]   m_HTRANS,
    output logic [2:0]   m_HSIZE,
    output logic         m_HWRITE,
    output logic [31:0]  m_HWDATA,
    input  logic         m_HREADY,
    input  logic [31:0]  m_HRDATA,
    input  logic         flush,
    output logic         hit,
    output logic         miss,
    output psram_state_e dbg_state
);

    localparam int IW  = $clog2(LINE_WORDS);
    localparam int OFF = IW + 2;
    localparam int TW  = AW - 1 - OFF;

    psram_state_e  state, state_nx;
    logic [31:0]   cap_addr;
    logic [2:0]    cap_size;
    logic          cap_write;
    logic          valid, flush_pend;
    logic [TW-1:0] tag;
    logic [IW-1:0] k, cnt;
    logic [31:0]   rdata_q;
    logic          hit_q, miss_q;

    logic          idle_like, accept, acc_cfg, acc_hit;
    logic [TW-1:0] s_tag, cap_tag;
    logic [IW-1:0] s_wi, cap_wi;
    logic          cap_cfg, fill_last, fill_step, fill_done, pass_done, wr_hit;
    logic          st_we;
    logic [3:0]    st_be;
    logic [IW-1:0] st_waddr;
    logic [31:0]   st_wdata, st_rdata;

    assign s_tag   = s_HADDR[AW-2:OFF];
    assign s_wi    = s_HADDR[OFF-1:2];
    assign cap_tag = cap_addr[AW-2:OFF];
    assign cap_wi  = cap_addr[OFF-1:2];
    assign cap_cfg = cap_addr[AW-1];

    // Only IDLE and RESP present HREADYOUT=1, so only they may take a new address phase.
    assign idle_like = (state == ST_IDLE) || (state == ST_RESP);
    assign accept    = s_HSEL && s_HREADY && idle_like &&
                       ((s_HTRANS == HTRANS_NONSEQ) || (s_HTRANS == HTRANS_SEQ));
    assign acc_cfg   = s_HADDR[AW-1];
    assign acc_hit   = !s_HWRITE && !acc_cfg && valid && (s_tag == tag);

    assign fill_last = (cnt == IW'(LINE_WORDS - 1));
    assign fill_step = (state == ST_FILL_D) && m_HREADY;
    assign fill_done = fill_step && fill_last;
    assign pass_done = (state == ST_PASS_D) && m_HREADY;
    assign wr_hit    = pass_done && cap_write && !cap_cfg && valid && (cap_tag == tag);

    // The store is written by fill words (full word) or by a write-hit merge (byte lanes).
    assign st_we    = fill_step || wr_hit;
    assign st_be    = fill_step ? 4'b1111 : lane_mask(cap_size, cap_addr[1:0]);
    assign st_waddr = fill_step ? k : cap_wi;
    assign st_wdata = fill_step ? m_HRDATA : m_HWDATA;

    psram_line_store #(.LINE_WORDS(LINE_WORDS)) u_store (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .we      (st_we),
        .be      (st_be),
        .waddr   (st_waddr),
        .wdata   (st_wdata),
        .raddr   (s_wi),
        .rdata   (st_rdata)
    );

    always_comb begin
        state_nx    = state;
        s_HREADYOUT = 1'b0;
        m_HSEL      = 1'b0;
        m_HTRANS    = HTRANS_IDLE;
        m_HADDR     = '0;
        m_HSIZE     = '0;
        m_HWRITE    = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                s_HREADYOUT = 1'b1;
                state_nx    = ST_IDLE;
                if (accept) begin
                    if (s_HWRITE || acc_cfg) state_nx = ST_PASS_A;
                    else if (!acc_hit)       state_nx = ST_FILL_A;
                end
            end
            ST_FILL_A: begin
                m_HSEL   = 1'b1;
                m_HTRANS = HTRANS_NONSEQ;
                m_HADDR  = {cap_addr[31:OFF], k, 2'b00};
                m_HSIZE  = HSIZE_WORD;
                if (m_HREADY) state_nx = ST_FILL_D;
            end
            ST_FILL_D: begin
                if (m_HREADY) state_nx = fill_last ? ST_RESP : ST_FILL_A;
            end
            ST_PASS_A: begin
                m_HSEL   = 1'b1;
                m_HTRANS = HTRANS_NONSEQ;
                m_HADDR  = cap_addr;
                m_HSIZE  = cap_size;
                m_HWRITE = cap_write;
                if (m_HREADY) state_nx = ST_PASS_D;
            end
            ST_PASS_D: begin
                if (m_HREADY) state_nx = ST_RESP;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            cap_addr   <= '0;
            cap_size   <= '0;
            cap_write  <= 1'b0;
            valid      <= 1'b0;
            flush_pend <= 1'b0;
            tag        <= '0;
            k          <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            m_HWDATA   <= '0;
        end else begin
            state  <= state_nx;
            hit_q  <= accept && acc_hit;
            miss_q <= accept && !s_HWRITE && !acc_cfg && !acc_hit;
            if (accept) begin
                cap_addr  <= s_HADDR;
                cap_size  <= s_HSIZE;
                cap_write <= s_HWRITE;
                k         <= s_wi;
                cnt       <= '0;
            end
            if (accept && acc_hit) rdata_q <= st_rdata;
            // Master holds HWDATA through the stalled data phase; latch it for PASS_D.
            if (state == ST_PASS_A) m_HWDATA <= s_HWDATA;
            if (fill_step) begin
                if (cnt == '0) rdata_q <= m_HRDATA;
                k   <= k + 1'b1;
                cnt <= cnt + 1'b1;
            end
            if (pass_done && !cap_write) rdata_q <= m_HRDATA;

            if (fill_done) begin
                valid      <= !(flush_pend || flush);
                tag        <= cap_tag;
                flush_pend <= 1'b0;
            end else if (pass_done) begin
                if ((cap_write && cap_cfg) || flush_pend || flush) valid <= 1'b0;
                flush_pend <= 1'b0;
            end else if (flush) begin
                if (idle_like) valid <= 1'b0;
                else           flush_pend <= 1'b1;
            end
        end
    end

    assign s_HRDATA  = rdata_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_psram_ahbl_line_buffer.sv
// Directed bench for psram_ahbl_line_buffer: an AHB-Lite master driver, a PSRAM slave
// model with optional wait states, and a log of downstream address phases.
module tb_psram_ahbl_line_buffer;
  import psram_pkg::*;

  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic         s_HSEL = 1'b0;
  logic [31:0]  s_HADDR = '0;
  logic [1:0]   s_HTRANS = '0;
  logic [2:0]   s_HSIZE = '0;
  logic         s_HWRITE = 1'b0;
  logic [31:0]  s_HWDATA = '0;
  logic         s_HREADY;
  logic         s_HREADYOUT;
  logic [31:0]  s_HRDATA;
  logic         m_HSEL;
  logic [31:0]  m_HADDR;
  logic [1:0]   m_HTRANS;
  logic [2:0]   m_HSIZE;
  logic         m_HWRITE;
  logic [31:0]  m_HWDATA;
  logic         m_HREADY;
  logic [31:0]  m_HRDATA;
  logic         flush = 1'b0;
  logic         hit, miss;
  psram_state_e dbg_state;

  int errors = 0;
  int checks = 0;

  assign s_HREADY = s_HREADYOUT;

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  psram_ahbl_line_buffer dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .s_HSEL      (s_HSEL),
    .s_HADDR     (s_HADDR),
    .s_HTRANS    (s_HTRANS),
    .s_HSIZE     (s_HSIZE),
    .s_HWRITE    (s_HWRITE),
    .s_HWDATA    (s_HWDATA),
    .s_HREADY    (s_HREADY),
    .s_HREADYOUT (s_HREADYOUT),
    .s_HRDATA    (s_HRDATA),
    .m_HSEL      (m_HSEL),
    .m_HADDR     (m_HADDR),
    .m_HTRANS    (m_HTRANS),
    .m_HSIZE     (m_HSIZE),
    .m_HWRITE    (m_HWRITE),
    .m_HWDATA    (m_HWDATA),
    .m_HREADY    (m_HREADY),
    .m_HRDATA    (m_HRDATA),
    .flush       (flush),
    .hit         (hit),
    .miss        (miss),
    .dbg_state   (dbg_state)
  );

  // ---------------- PSRAM slave model ----------------
  // Word at byte address A initialises to 0xC0DE0000 | A.
  logic [31:0] mem [1024];
  logic [31:0] cfg_reg;
  logic        sl_pend, sl_wr;
  logic [31:0] sl_addr;
  logic [2:0]  sl_size;
  int          sl_wait;
  int          ws = 0;
  logic [35:0] xfer_q[$];
  logic [35:0] exp_q[$];

  assign m_HREADY = !sl_pend || (sl_wait == 0);
  assign m_HRDATA = (sl_pend && !sl_wr) ? (sl_addr[23] ? cfg_reg : mem[sl_addr[11:2]]) : 32'h0;

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      3'd0:    be = 4'b0001 << a;
      3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    lane_merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) lane_merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | (i << 2);
      cfg_reg <= '0;
      sl_pend <= 1'b0;
      sl_wr   <= 1'b0;
      sl_addr <= '0;
      sl_size <= '0;
      sl_wait <= 0;
    end else if (m_HREADY) begin
      if (sl_pend && sl_wr) begin
        if (sl_addr[23]) cfg_reg <= m_HWDATA;
        else mem[sl_addr[11:2]] <= lane_merge(mem[sl_addr[11:2]], m_HWDATA, sl_size, sl_addr[1:0]);
      end
      sl_pend <= m_HSEL && m_HTRANS[1];
      if (m_HSEL && m_HTRANS[1]) begin
        sl_addr <= m_HADDR;
        sl_wr   <= m_HWRITE;
        sl_size <= m_HSIZE;
        sl_wait <= ws;
        xfer_q.push_back({m_HWRITE, m_HSIZE, m_HADDR});
      end
    end else begin
      sl_wait <= sl_wait - 1;
    end
  end

  // ---------------- master driver tasks ----------------
  logic [31:0] rd_data;
  logic        rd_hit, rd_miss;
  int          rd_waits;

  task automatic ahb_read(input logic [31:0] a);
    int n;
    @(negedge HCLK);
    s_HSEL = 1'b1; s_HADDR = a; s_HTRANS = 2'b10; s_HWRITE = 1'b0; s_HSIZE = 3'd2;
    n = 0;
    while (!s_HREADYOUT && n < 100) begin @(negedge HCLK); n++; end
    @(negedge HCLK);
    s_HSEL = 1'b0; s_HTRANS = 2'b00;
    rd_hit = hit; rd_miss = miss; rd_waits = 0;
    while (!s_HREADYOUT && rd_waits < 200) begin @(negedge HCLK); rd_waits++; end
    rd_data = s_HRDATA;
    checks++;
    if (rd_waits >= 200) begin
      errors++;
      $display("FAIL read_timeout addr=%h waits=%0d required<200", a, rd_waits);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int n;
    @(negedge HCLK);
    s_HSEL = 1'b1; s_HADDR = a; s_HTRANS = 2'b10; s_HWRITE = 1'b1; s_HSIZE = sz;
    n = 0;
    while (!s_HREADYOUT && n < 100) begin @(negedge HCLK); n++; end
    @(negedge HCLK);
    s_HSEL = 1'b0; s_HTRANS = 2'b00; s_HWRITE = 1'b0; s_HWDATA = d;
    n = 0;
    while (!s_HREADYOUT && n < 200) begin @(negedge HCLK); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL write_timeout addr=%h waits=%0d required<200", a, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge HCLK);
    checks++;
    if ({s_HREADYOUT, s_HRDATA, hit, miss} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_upstream got rdy=%b rdata=%h hit=%b miss=%b required 1/0/0/0",
               s_HREADYOUT, s_HRDATA, hit, miss);
    end
    checks++;
    if ({m_HSEL, m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA} !== 71'h0) begin
      errors++;
      $display("FAIL reset_downstream got sel=%b addr=%h trans=%0d size=%0d wr=%b wdata=%h required all 0",
               m_HSEL, m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if (s_HREADYOUT !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got %b required 1", s_HREADYOUT);
    end
  endtask

  task automatic test_miss_fill();
    xfer_q.delete(); exp_q.delete();
    ahb_read(32'h0000_0104);
    checks++;
    if (rd_data !== 32'hC0DE_0104) begin errors++; $display("FAIL miss_data got %h required c0de0104", rd_data); end
    checks++;
    if ({rd_miss, rd_hit} !== 2'b10) begin errors++; $display("FAIL miss_pulse got miss=%b hit=%b required 1/0", rd_miss, rd_hit); end
    checks++;
    if (rd_waits !== 8) begin errors++; $display("FAIL miss_waits got %0d required 8", rd_waits); end
    exp_q.push_back({1'b0, 3'd2, 32'h104});
    exp_q.push_back({1'b0, 3'd2, 32'h108});
    exp_q.push_back({1'b0, 3'd2, 32'h10C});
    exp_q.push_back({1'b0, 3'd2, 32'h100});
    checks++;
    if (xfer_q.size() != exp_q.size()) begin
      errors++; $display("FAIL miss_xfer_count got %0d required %0d", xfer_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (xfer_q[i] !== exp_q[i]) begin errors++; $display("FAIL miss_xfer[%0d] got %h required %h", i, xfer_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_hit();
    xfer_q.delete();
    ahb_read(32'h0000_010C);
    checks++;
    if (rd_data !== 32'hC0DE_010C) begin errors++; $display("FAIL hit_data got %h required c0de010c", rd_data); end
    checks++;
    if ({rd_hit, rd_miss, rd_waits[3:0]} !== 6'b10_0000) begin
      errors++; $display("FAIL hit_pulse got hit=%b miss=%b waits=%0d required 1/0/0", rd_hit, rd_miss, rd_waits);
    end
    ahb_read(32'h0000_0100);
    checks++;
    if ({rd_hit, rd_data} !== {1'b1, 32'hC0DE_0100}) begin
      errors++; $display("FAIL hit_base got hit=%b data=%h required 1/c0de0100", rd_hit, rd_data);
    end
    checks++;
    if (xfer_q.size() != 0) begin errors++; $display("FAIL hit_no_xfer got %0d required 0", xfer_q.size()); end
  endtask

  task automatic test_byte_write();
    xfer_q.delete();
    ahb_write(32'h0000_0102, 3'd0, 32'h00AB_0000);
    checks++;
    if (xfer_q.size() != 1) begin
      errors++; $display("FAIL bytewr_count got %0d required 1", xfer_q.size());
    end else begin
      checks++;
      if (xfer_q[0] !== {1'b1, 3'd0, 32'h102}) begin
        errors++; $display("FAIL bytewr_xfer got %h required %h", xfer_q[0], {1'b1, 3'd0, 32'h102});
      end
    end
    checks++;
    if (mem[64] !== 32'hC0AB_0100) begin errors++; $display("FAIL bytewr_psram got %h required c0ab0100", mem[64]); end
    xfer_q.delete();
    ahb_read(32'h0000_0100);
    checks++;
    if ({rd_hit, rd_data} !== {1'b1, 32'hC0AB_0100}) begin
      errors++; $display("FAIL bytewr_merge got hit=%b data=%h required 1/c0ab0100", rd_hit, rd_data);
    end
    ahb_write(32'h0000_010A, 3'd1, 32'h5A5A_0000);
    ahb_read(32'h0000_0108);
    checks++;
    if ({rd_hit, rd_data} !== {1'b1, 32'h5A5A_0108}) begin
      errors++; $display("FAIL halfwr_merge got hit=%b data=%h required 1/5a5a0108", rd_hit, rd_data);
    end
    checks++;
    if (xfer_q.size() != 1) begin errors++; $display("FAIL halfwr_count got %0d required 1", xfer_q.size()); end
  endtask

  task automatic test_cfg_write();
    xfer_q.delete();
    ahb_write(32'h0080_2000, 3'd2, 32'h0000_0003);
    checks++;
    if (cfg_reg !== 32'h3) begin errors++; $display("FAIL cfgwr_reg got %h required 00000003", cfg_reg); end
    checks++;
    if (xfer_q.size() != 1 || xfer_q[0] !== {1'b1, 3'd2, 32'h0080_2000}) begin
      errors++; $display("FAIL cfgwr_xfer got count=%0d first=%h required 1/%h", xfer_q.size(), xfer_q[0], {1'b1, 3'd2, 32'h0080_2000});
    end
    xfer_q.delete();
    ahb_read(32'h0080_0000);
    checks++;
    if ({rd_hit, rd_miss, rd_data} !== {2'b00, 32'h3} || xfer_q.size() != 1) begin
      errors++; $display("FAIL cfgrd got hit=%b miss=%b data=%h xfers=%0d required 0/0/00000003/1", rd_hit, rd_miss, rd_data, xfer_q.size());
    end
    xfer_q.delete(); exp_q.delete();
    ahb_read(32'h0000_0100);
    checks++;
    if ({rd_miss, rd_data} !== {1'b1, 32'hC0AB_0100}) begin
      errors++; $display("FAIL cfg_refetch got miss=%b data=%h required 1/c0ab0100", rd_miss, rd_data);
    end
    exp_q.push_back({1'b0, 3'd2, 32'h100});
    exp_q.push_back({1'b0, 3'd2, 32'h104});
    exp_q.push_back({1'b0, 3'd2, 32'h108});
    exp_q.push_back({1'b0, 3'd2, 32'h10C});
    checks++;
    if (xfer_q.size() != exp_q.size()) begin
      errors++; $display("FAIL refetch_count got %0d required %0d", xfer_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (xfer_q[i] !== exp_q[i]) begin errors++; $display("FAIL refetch_xfer[%0d] got %h required %h", i, xfer_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_flush_fill();
    fork
      ahb_read(32'h0000_0208);
      begin
        repeat (4) @(negedge HCLK);
        flush = 1'b1;
        @(negedge HCLK);
        flush = 1'b0;
      end
    join
    checks++;
    if ({rd_miss, rd_data} !== {1'b1, 32'hC0DE_0208}) begin
      errors++; $display("FAIL flushfill_data got miss=%b data=%h required 1/c0de0208", rd_miss, rd_data);
    end
    xfer_q.delete();
    ahb_read(32'h0000_0208);
    checks++;
    if ({rd_miss, rd_hit, rd_data} !== {2'b10, 32'hC0DE_0208}) begin
      errors++; $display("FAIL flushfill_remiss got miss=%b hit=%b data=%h required 1/0/c0de0208", rd_miss, rd_hit, rd_data);
    end
    checks++;
    if (xfer_q.size() != 4 || xfer_q[2] !== {1'b0, 3'd2, 32'h200}) begin
      errors++; $display("FAIL flushfill_xfers got count=%0d third=%h required 4/%h", xfer_q.size(), xfer_q[2], {1'b0, 3'd2, 32'h200});
    end
    ahb_read(32'h0000_020C);
    checks++;
    if ({rd_hit, rd_data} !== {1'b1, 32'hC0DE_020C}) begin
      errors++; $display("FAIL flushfill_rehit got hit=%b data=%h required 1/c0de020c", rd_hit, rd_data);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge HCLK); flush = 1'b1;
    @(negedge HCLK); flush = 1'b0;
    ahb_read(32'h0000_0204);
    checks++;
    if ({rd_miss, rd_data} !== {1'b1, 32'hC0DE_0204}) begin
      errors++; $display("FAIL flushidle got miss=%b data=%h required 1/c0de0204", rd_miss, rd_data);
    end
  endtask

  task automatic test_idle_ignored();
    int bad;
    xfer_q.delete();
    bad = 0;
    @(negedge HCLK);
    s_HSEL = 1'b1; s_HADDR = 32'h0000_0500; s_HTRANS = 2'b01;
    @(negedge HCLK); bad += (s_HREADYOUT !== 1'b1 || hit || miss) ? 1 : 0;
    s_HTRANS = 2'b00;
    @(negedge HCLK); bad += (s_HREADYOUT !== 1'b1 || hit || miss) ? 1 : 0;
    s_HSEL = 1'b0; s_HTRANS = 2'b10;
    @(negedge HCLK); bad += (s_HREADYOUT !== 1'b1 || hit || miss) ? 1 : 0;
    s_HTRANS = 2'b00;
    @(negedge HCLK);
    checks++;
    if (bad != 0 || xfer_q.size() != 0) begin
      errors++; $display("FAIL idle_ignored got bad_cycles=%0d xfers=%0d required 0/0", bad, xfer_q.size());
    end
  endtask

  task automatic test_wait_states();
    ws = 2;
    ahb_read(32'h0000_0304);
    ws = 0;
    checks++;
    if ({rd_miss, rd_data} !== {1'b1, 32'hC0DE_0304}) begin
      errors++; $display("FAIL ws_data got miss=%b data=%h required 1/c0de0304", rd_miss, rd_data);
    end
    checks++;
    if (rd_waits !== 16) begin errors++; $display("FAIL ws_waits got %0d required 16", rd_waits); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_data, b_data;
    logic        a_hit, b_hit;
    xfer_q.delete();
    @(negedge HCLK);
    s_HSEL = 1'b1; s_HADDR = 32'h0000_0300; s_HTRANS = 2'b10; s_HWRITE = 1'b0; s_HSIZE = 3'd2;
    @(negedge HCLK);
    a_data = s_HRDATA; a_hit = hit;
    s_HADDR = 32'h0000_0308;
    @(negedge HCLK);
    b_data = s_HRDATA; b_hit = hit;
    s_HSEL = 1'b0; s_HTRANS = 2'b00;
    checks++;
    if ({a_hit, a_data} !== {1'b1, 32'hC0DE_0300}) begin
      errors++; $display("FAIL b2b_first got hit=%b data=%h required 1/c0de0300", a_hit, a_data);
    end
    checks++;
    if ({b_hit, b_data} !== {1'b1, 32'hC0DE_0308} || xfer_q.size() != 0) begin
      errors++; $display("FAIL b2b_second got hit=%b data=%h xfers=%0d required 1/c0de0308/0", b_hit, b_data, xfer_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    @(negedge HCLK);
    s_HSEL = 1'b1; s_HADDR = 32'h0000_040C; s_HTRANS = 2'b10; s_HWRITE = 1'b0; s_HSIZE = 3'd2;
    @(negedge HCLK);
    s_HSEL = 1'b0; s_HTRANS = 2'b00;
    n = 0;
    while (dbg_state != ST_FILL_D && n < 50) begin @(negedge HCLK); n++; end
    checks++;
    if (dbg_state !== ST_FILL_D) begin errors++; $display("FAIL rst_reach_fill got state=%0d required %0d", dbg_state, ST_FILL_D); end
    #1 HRESETn = 1'b0;
    #1;
    checks++;
    if ({s_HREADYOUT, m_HTRANS, m_HSEL, m_HADDR, miss} !== {1'b1, 2'b00, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL rst_outputs got rdy=%b trans=%0d sel=%b addr=%h miss=%b required 1/0/0/0/0",
                         s_HREADYOUT, m_HTRANS, m_HSEL, m_HADDR, miss);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d required %0d", dbg_state, ST_IDLE); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    ahb_read(32'h0000_0300);
    checks++;
    if ({rd_miss, rd_hit, rd_data} !== {2'b10, 32'hC0DE_0300}) begin
      errors++; $display("FAIL rst_remiss got miss=%b hit=%b data=%h required 1/0/c0de0300", rd_miss, rd_hit, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_byte_write();
    test_cfg_write();
    test_flush_fill();
    test_flush_idle();
    test_idle_ignored();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_fill();
    repeat (2) @(negedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached 200000ns");
    $fatal(1, "timeout");
  end

endmodule
